// File: rtl/ti_pipe_in_bank.sv
// ti_pipe_in_bank: multi-channel host-to-user pipe-in buffer bank.
//
// Each channel packs PACK consecutive 16-bit host words (little-endian) into
// one USER_WIDTH = 16*PACK word. The packed word goes into a small FIFO whose
// last stage is a registered output. Free host-word space, rounded down to a
// block boundary, is reported back to the host.
//
// Ports:
//   ti_clk           clock for all logic
//   ti_rst_n         synchronous active-low reset
//   ti_flush         per-channel synchronous flush, active high
//   ti_in_data_en    per-channel host word strobe
//   ti_in_data       host words, channel c at [16c +: 16]
//   ti_in_available  free host-word space per channel, block-rounded, registered
//   ti_in_overflow   per-channel sticky dropped-word flag
//   out_valid        per-channel user word available
//   out_ready        per-channel user accept
//   out_data         packed user words, channel c at [USER_WIDTH*c +: USER_WIDTH]
module ti_pipe_in_bank #(
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned PACK       = 2,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned BLOCK_LOG2 = 2
) (
   input  logic                        ti_clk,
   input  logic                        ti_rst_n,
   input  logic [NUM_CH-1:0]           ti_flush,
   input  logic [NUM_CH-1:0]           ti_in_data_en,
   input  logic [16*NUM_CH-1:0]        ti_in_data,
   output logic [16*NUM_CH-1:0]        ti_in_available,
   output logic [NUM_CH-1:0]           ti_in_overflow,
   output logic [NUM_CH-1:0]           out_valid,
   input  logic [NUM_CH-1:0]           out_ready,
   output logic [16*PACK*NUM_CH-1:0]   out_data
);

   localparam int unsigned USER_WIDTH = 16 * PACK;
   localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
   localparam int unsigned CNT_W      = (PACK > 1) ? $clog2(PACK) : 1;
   localparam logic [31:0] BLK_MASK   = (32'd1 << BLOCK_LOG2) - 32'd1;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      // Fill counts every user word held, output register included.
      logic [ADDR_WIDTH:0]     r_fill;
      logic [ADDR_WIDTH-1:0]   r_wptr;
      logic [ADDR_WIDTH-1:0]   r_rptr;
      logic [CNT_W-1:0]        r_pack_cnt;
      logic [USER_WIDTH-1:0]   r_pack;
      logic [USER_WIDTH-1:0]   r_mem [DEPTH];
      logic [USER_WIDTH-1:0]   r_out;
      logic                    r_valid;
      logic                    r_ovf;
      logic [15:0]             r_avail;

      logic                    w_en;
      logic                    w_flush;
      logic [15:0]             w_data;
      logic                    w_full;
      logic                    w_accept;
      logic                    w_complete;
      logic                    w_pop;
      logic                    w_mem_nonempty;
      logic                    w_load;
      logic [USER_WIDTH-1:0]   w_word;
      logic [31:0]             w_free;
      logic [31:0]             w_free_blk;
      logic [15:0]             w_avail;

      assign w_en    = ti_in_data_en[c];
      assign w_flush = ti_flush[c];
      assign w_data  = ti_in_data[16*c +: 16];

      // Full is judged on the pre-edge fill, so a same-cycle pop never frees
      // room for a write.
      assign w_full     = (r_fill == (ADDR_WIDTH+1)'(DEPTH));
      assign w_accept   = w_en & ~w_flush & ~w_full;
      assign w_complete = w_accept & (r_pack_cnt == CNT_W'(PACK - 1));
      assign w_pop      = r_valid & out_ready[c];

      // Words in memory = fill minus the one held in the output register.
      assign w_mem_nonempty = (r_fill > (ADDR_WIDTH+1)'(r_valid));
      assign w_load         = (~r_valid | w_pop) & w_mem_nonempty;

      // Incoming host word merged into its little-endian slot.
      always_comb begin
         w_word = r_pack;
         w_word[16*r_pack_cnt +: 16] = w_data;
      end

      always_comb begin
         w_free     = (32'(DEPTH) - 32'(r_fill)) * 32'(PACK) - 32'(r_pack_cnt);
         w_free_blk = w_free & ~BLK_MASK;
         w_avail    = (w_free_blk > 32'h0000_FFFF) ? 16'hFFFF : w_free_blk[15:0];
      end

      // Storage array carries no reset; pointers and fill define its content.
      always_ff @(posedge ti_clk) begin
         if (w_complete) begin
            r_mem[r_wptr] <= w_word;
         end
      end

      always_ff @(posedge ti_clk) begin
         if (!ti_rst_n) begin
            r_fill     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_pack_cnt <= '0;
            r_pack     <= '0;
            r_out      <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
            r_avail    <= '0;
         end else if (w_flush) begin
            r_fill     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_pack_cnt <= '0;
            r_pack     <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
            r_avail    <= w_avail;
         end else begin
            r_avail <= w_avail;

            if (w_en && w_full) begin
               r_ovf <= 1'b1;
            end

            if (w_accept) begin
               if (w_complete) begin
                  r_pack_cnt <= '0;
                  r_pack     <= '0;
                  r_wptr     <= r_wptr + 1'b1;
               end else begin
                  r_pack_cnt <= r_pack_cnt + 1'b1;
                  r_pack     <= w_word;
               end
            end

            case ({w_complete, w_pop})
               2'b10:   r_fill <= r_fill + 1'b1;
               2'b01:   r_fill <= r_fill - 1'b1;
               default: r_fill <= r_fill;
            endcase

            if (w_load) begin
               r_out   <= r_mem[r_rptr];
               r_rptr  <= r_rptr + 1'b1;
               r_valid <= 1'b1;
            end else if (w_pop) begin
               r_valid <= 1'b0;
            end
         end
      end

      assign ti_in_available[16*c +: 16]           = r_avail;
      assign ti_in_overflow[c]                     = r_ovf;
      assign out_valid[c]                          = r_valid;
      assign out_data[USER_WIDTH*c +: USER_WIDTH]  = r_out;
   end

endmodule

// File: tb/tb_ti_pipe_in_bank.sv
// Self-checking bench for ti_pipe_in_bank: directed scenarios followed by
// randomized traffic, all compared against a queue-based behavioural model.
module tb_ti_pipe_in_bank;

   localparam int NCH   = 2;
   localparam int PACK  = 2;
   localparam int AW    = 4;
   localparam int BL    = 2;
   localparam int UW    = 16 * PACK;
   localparam int DEPTH = 1 << AW;

   logic                ti_clk = 1'b0;
   logic                ti_rst_n;
   logic [NCH-1:0]      ti_flush;
   logic [NCH-1:0]      ti_in_data_en;
   logic [16*NCH-1:0]   ti_in_data;
   logic [16*NCH-1:0]   ti_in_available;
   logic [NCH-1:0]      ti_in_overflow;
   logic [NCH-1:0]      out_valid;
   logic [NCH-1:0]      out_ready;
   logic [UW*NCH-1:0]   out_data;

   ti_pipe_in_bank #(
      .NUM_CH     (NCH),
      .PACK       (PACK),
      .ADDR_WIDTH (AW),
      .BLOCK_LOG2 (BL)
   ) u_dut (
      .ti_clk          (ti_clk),
      .ti_rst_n        (ti_rst_n),
      .ti_flush        (ti_flush),
      .ti_in_data_en   (ti_in_data_en),
      .ti_in_data      (ti_in_data),
      .ti_in_available (ti_in_available),
      .ti_in_overflow  (ti_in_overflow),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data)
   );

   always #5 ti_clk = ~ti_clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Model: every held user word with the edge it was written, plus the
   // host words of the unfinished pack.
   logic [UW-1:0] mq_data  [NCH][$];
   int            mq_stamp [NCH][$];
   logic [15:0]   mpart    [NCH][$];
   logic          m_ovf    [NCH];
   int            m_avail  [NCH];
   int            edge_no = 0;

   function automatic int free_of(input int c);
      int f;
      f = (DEPTH - mq_data[c].size()) * PACK - mpart[c].size();
      f = f & ~((1 << BL) - 1);
      return (f > 65535) ? 65535 : f;
   endfunction

   task automatic model_edge();
      edge_no++;
      for (int c = 0; c < NCH; c++) begin
         if (!ti_rst_n) begin
            mq_data[c].delete();
            mq_stamp[c].delete();
            mpart[c].delete();
            m_ovf[c]   = 1'b0;
            m_avail[c] = 0;
         end else begin
            m_avail[c] = free_of(c);
            if (ti_flush[c]) begin
               mq_data[c].delete();
               mq_stamp[c].delete();
               mpart[c].delete();
               m_ovf[c] = 1'b0;
            end else begin
               bit vis, pop, acc;
               vis = (mq_data[c].size() > 0) && (mq_stamp[c][0] < edge_no - 1);
               pop = vis && out_ready[c];
               acc = ti_in_data_en[c] && (mq_data[c].size() < DEPTH);
               if (ti_in_data_en[c] && !acc) m_ovf[c] = 1'b1;
               if (pop) begin
                  void'(mq_data[c].pop_front());
                  void'(mq_stamp[c].pop_front());
               end
               if (acc) begin
                  mpart[c].push_back(ti_in_data[16*c +: 16]);
                  if (mpart[c].size() == PACK) begin
                     logic [UW-1:0] w;
                     w = '0;
                     for (int k = 0; k < PACK; k++) w[16*k +: 16] = mpart[c][k];
                     mq_data[c].push_back(w);
                     mq_stamp[c].push_back(edge_no);
                     mpart[c].delete();
                  end
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      for (int c = 0; c < NCH; c++) begin
         bit ev;
         ev = (mq_data[c].size() > 0) && (mq_stamp[c][0] < edge_no);
         check($sformatf("valid%0d@%0d", c, edge_no), 64'(out_valid[c]), 64'(ev));
         check($sformatf("avail%0d@%0d", c, edge_no),
               64'(ti_in_available[16*c +: 16]), 64'(m_avail[c]));
         check($sformatf("ovf%0d@%0d", c, edge_no), 64'(ti_in_overflow[c]), 64'(m_ovf[c]));
         if (ev) begin
            check($sformatf("data%0d@%0d", c, edge_no),
                  64'(out_data[UW*c +: UW]), 64'(mq_data[c][0]));
         end
         if (!ti_rst_n) begin
            check($sformatf("rstdata%0d@%0d", c, edge_no), 64'(out_data[UW*c +: UW]), 64'd0);
         end
      end
   endtask

   task automatic tick();
      @(posedge ti_clk);
      model_edge();
      @(negedge ti_clk);
      compare_all();
   endtask

   task automatic idle();
      ti_flush      = '0;
      ti_in_data_en = '0;
   endtask

   int min_av1;
   int vcount;

   initial begin
      ti_rst_n      = 1'b0;
      ti_flush      = '0;
      ti_in_data_en = '0;
      ti_in_data    = '0;
      out_ready     = '0;
      for (int c = 0; c < NCH; c++) begin
         m_ovf[c]   = 1'b0;
         m_avail[c] = 0;
      end
      @(negedge ti_clk);

      // 1: reset then release
      repeat (3) tick();
      check("t1_rst_avail", 64'(ti_in_available), 64'd0);
      ti_rst_n = 1'b1;
      tick();
      check("t1_avail0", 64'(ti_in_available[15:0]), 64'd32);
      check("t1_avail1", 64'(ti_in_available[31:16]), 64'd32);
      check("t1_valid", 64'(out_valid), 64'd0);

      // 2: one packed word on ch0
      ti_in_data_en[0] = 1'b1; ti_in_data[15:0] = 16'h1111; tick();
      ti_in_data[15:0] = 16'h2222; tick();
      check("t2_avail0_a", 64'(ti_in_available[15:0]), 64'd28);
      check("t2_novalid", 64'(out_valid[0]), 64'd0);
      idle(); tick();
      check("t2_valid", 64'(out_valid[0]), 64'd1);
      check("t2_data", 64'(out_data[31:0]), 64'h2222_1111);
      check("t2_avail0_b", 64'(ti_in_available[15:0]), 64'd28);
      check("t2_avail1", 64'(ti_in_available[31:16]), 64'd32);

      // 3: fill to overflow, then drain
      ti_flush[0] = 1'b1; tick(); idle(); tick();
      for (int i = 0; i < 32; i++) begin
         ti_in_data_en[0] = 1'b1; ti_in_data[15:0] = 16'(i); tick();
      end
      ti_in_data[15:0] = 16'd99; tick();
      idle();
      check("t3_avail0_zero", 64'(ti_in_available[15:0]), 64'd0);
      check("t3_ovf", 64'(ti_in_overflow[0]), 64'd1);
      check("t3_first", 64'(out_data[31:0]), 64'h0001_0000);
      out_ready[0] = 1'b1;
      repeat (18) tick();
      out_ready[0] = 1'b0;
      check("t3_avail0_back", 64'(ti_in_available[15:0]), 64'd32);
      check("t3_ovf_sticky", 64'(ti_in_overflow[0]), 64'd1);

      // 4: flush with a concurrent write
      ti_in_data_en[0] = 1'b1; ti_in_data[15:0] = 16'hAAAA; tick();
      ti_flush[0] = 1'b1; ti_in_data[15:0] = 16'hBBBB; tick();
      check("t4_ovf_clr", 64'(ti_in_overflow[0]), 64'd0);
      idle(); tick();
      check("t4_avail0", 64'(ti_in_available[15:0]), 64'd32);
      ti_in_data_en[0] = 1'b1; ti_in_data[15:0] = 16'h0001; tick();
      ti_in_data[15:0] = 16'h0002; tick();
      idle(); tick();
      check("t4_data", 64'(out_data[31:0]), 64'h0002_0001);

      // 5: ch1 streaming with ready held high
      min_av1 = 65535; vcount = 0;
      out_ready[1] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         ti_in_data_en[1] = 1'b1; ti_in_data[31:16] = 16'(16'h100 + i); tick();
         if (i > 2 && int'(ti_in_available[31:16]) < min_av1) min_av1 = ti_in_available[31:16];
         if (out_valid[1]) vcount++;
      end
      idle(); out_ready[1] = 1'b0;
      check("t5_min_avail", 64'(min_av1 >= 28), 64'd1);
      check("t5_vcount", 64'(vcount), 64'd19);
      check("t5_ovf1", 64'(ti_in_overflow[1]), 64'd0);

      // 6: reset mid-stream with a partial pack held
      for (int i = 0; i < 9; i++) begin
         ti_in_data_en[0] = 1'b1; ti_in_data[15:0] = 16'(16'h300 + i); tick();
      end
      ti_rst_n = 1'b0; ti_in_data[15:0] = 16'hDEAD;
      repeat (2) tick();
      check("t6_rst_valid", 64'(out_valid), 64'd0);
      check("t6_rst_avail", 64'(ti_in_available), 64'd0);
      check("t6_rst_data", 64'(out_data), 64'd0);
      idle(); ti_rst_n = 1'b1; tick();
      check("t6_avail0", 64'(ti_in_available[15:0]), 64'd32);
      ti_in_data_en[0] = 1'b1; ti_in_data[15:0] = 16'h5555; tick();
      ti_in_data[15:0] = 16'h6666; tick();
      idle(); tick();
      check("t6_data", 64'(out_data[31:0]), 64'h6666_5555);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         ti_rst_n = ($urandom_range(0, 599) != 0);
         for (int c = 0; c < NCH; c++) begin
            ti_flush[c]         = ($urandom_range(0, 79) == 0);
            ti_in_data_en[c]    = ($urandom_range(0, 3) != 0);
            ti_in_data[16*c +: 16] = 16'($urandom);
            out_ready[c]        = ($urandom_range(0, 2) == 0) ^ (i[9] == 1'b1);
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ti_pipe_in_bank.md
Name: ti_pipe_in_bank

Overview:
Multi-channel host-to-user pipe-in buffer bank. It is the parametrised successor to the single-channel pipe-in buffer used by project modules behind okPipeIn endpoints.
Each channel packs PACK consecutive 16-bit host words into one USER_WIDTH word and buffers it in a FIFO. It reports block-rounded free space to the host through a wire-out value and presents packed words to user logic with a valid/ready handshake.
Single clock domain (ti_clk). It sits between the okPipeIn/okWireOut endpoint arrays and project logic.

Parameters:
NUM_CH, 2, number of independent channels (1–16)
PACK, 2, host words per user word (1, 2, 4); USER_WIDTH = 16*PACK
ADDR_WIDTH, 4, FIFO depth DEPTH = 2^ADDR_WIDTH user words per channel (output register included)
BLOCK_LOG2, 2, free-space report granularity = 2^BLOCK_LOG2 host words

Ports:
ti_clk  in  1  clock for all logic
ti_rst_n  in  1  synchronous active-low reset
ti_flush  in  NUM_CH  per-channel synchronous flush, active high
ti_in_data_en  in  NUM_CH  host word strobe (okPipeIn ep_write)
ti_in_data  in  16*NUM_CH  host word; channel c at [16c +: 16]
ti_in_available  out  16*NUM_CH  free host-word space, block-rounded, registered
ti_in_overflow  out  NUM_CH  sticky dropped-word flag
out_valid  out  NUM_CH  user word available
out_ready  in  NUM_CH  user accepts word
out_data  out  USER_WIDTH*NUM_CH  packed word; channel c at [USER_WIDTH*c +: USER_WIDTH]

Behaviour:
- Reset (ti_rst_n=0 at an edge): all channel state cleared. Outputs 0: available, overflow, out_valid, out_data. Available shows the true value one edge after reset deasserts.
- Per-channel state: pack_cnt (0..PACK-1), pack_reg, FIFO fill (0..DEPTH), write/read pointers, output register.
- Channels are fully independent; no shared arbitration.
- Packing is little-endian: first host word goes to bits [15:0], the k-th word to [16k +: 16].
- The word completing a pack is combined with pack_reg and written to the FIFO at the same edge. pack_cnt then returns to 0.
- Acceptance: a host word is accepted iff fill < DEPTH.
  - Invariant: fill == DEPTH implies pack_cnt == 0.
  - Rejected word: dropped, ti_in_overflow set (sticky), state unchanged.
  - A pop in the same cycle does not make room for a write in that cycle.
- free_raw = (DEPTH - fill)*PACK - pack_cnt; always ≥ 0.
- ti_in_available = min(free_raw with low BLOCK_LOG2 bits cleared, 16'hFFFF). Registered, so it reflects state one edge late.
- Output stage is a FIFO with a registered data output:
  - out_valid is high while the output register holds a word.
  - The register loads from memory when it is empty or being popped (out_valid & out_ready) and memory is non-empty.
  - Write-to-valid latency: completing host word at edge N, out_valid high after edge N+1 (empty FIFO).
  - Sustained throughput: one user word per cycle.
- Simultaneous pack-completion write and pop: fill unchanged, both take effect.
- Pointers wrap modulo DEPTH.
- out_data holds its value while out_valid & ~out_ready.
- ti_flush[c]: at that edge clears the channel's pointers, fill, pack_cnt, pack_reg, out_valid and overflow.
  - Host word presented in the same cycle is discarded silently (no overflow).
  - Other channels are unaffected.
- Reset overrides flush. Reset mid-pack discards the partial word.

Test Plan:
1. Defaults; release reset, idle -> after 1 edge ti_in_available = 32 on both channels; out_valid=0; overflow=0.
2. ch0 writes 16'h1111 then 16'h2222, out_ready=0 -> available0 28 after each word; out_data0 = 32'h2222_1111 with out_valid0=1 one edge after the second write; ch1 unchanged (32).
3. ch0 writes 32 words 0..31 with out_ready=0 -> available0 reaches 0; 33rd write sets overflow0=1 and is dropped. Then out_ready=1 drains 16 words {1,0},{3,2}…{31,30} on consecutive cycles; available0 returns to 32; overflow0 stays 1.
4. ch0 writes one word 16'hAAAA, then ti_flush0 with a concurrent write 16'hBBBB -> available0=32, overflow0=0. Next writes 16'h0001, 16'h0002 yield 32'h0002_0001 (no AAAA/BBBB).
5. ch1 continuous writes every cycle with out_ready1=1 -> out_valid1 every second cycle after startup; available1 never below 28; no overflow; ch0 state unchanged.
6. Reset asserted mid-stream, with ch0 holding 5 words and a partial pack -> all outputs 0 during reset; after release available0=32 and first packed word contains only post-reset data.
